// File: rtl/reg_dump_scanner.sv
// Sweeps the register-file debug read port over R0..R(NUM_REGS-1) and streams each word out on valid/ready.
// Optional checksum word enabled by defining REG_DUMP_CHECKSUM_EN.
module reg_dump_scanner #(
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_a4,
  input  logic [DATA_W-1:0] i_rd4,
  output logic [DATA_W-1:0] o_dout,
  output logic [ADDR_W-1:0] o_dout_idx,
  output logic              o_dout_valid,
  input  logic              i_dout_ready,
  output logic              o_busy,
  output logic              o_done
);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_CSUM, S_FIN} state_t;
  logic [DATA_W-1:0] r_csum;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_FIN} state_t;
`endif

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_a4, r_idx, r_dout_idx;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              w_last;

  assign w_last = (r_idx == ADDR_W'(NUM_REGS-1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_FETCH;
      S_FETCH: w_next = S_SEND;
      S_SEND:
        if (i_dout_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
          w_next = w_last ? S_CSUM : S_FETCH;
`else
          w_next = w_last ? S_FIN : S_FETCH;
`endif
        end
`ifdef REG_DUMP_CHECKSUM_EN
      S_CSUM:  if (r_valid && i_dout_ready) w_next = S_FIN;
`endif
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a4       <= '0;
      r_idx      <= '0;
      r_dout     <= '0;
      r_dout_idx <= '0;
      r_valid    <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE:
          if (i_start) begin
            r_a4  <= '0;
            r_idx <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            r_csum <= '0;
`endif
          end
        // A4 has been stable a whole cycle, so RD4 is settled here.
        S_FETCH: begin
          r_dout     <= i_rd4;
          r_dout_idx <= r_idx;
          r_valid    <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          r_csum     <= r_csum ^ i_rd4;
`endif
        end
        S_SEND:
          if (i_dout_ready) begin
            r_valid <= 1'b0;
            if (!w_last) begin
              r_idx <= r_idx + ADDR_W'(1);
              r_a4  <= r_idx + ADDR_W'(1);
            end
          end
`ifdef REG_DUMP_CHECKSUM_EN
        // First CSUM cycle loads the word, later cycles wait for accept.
        S_CSUM:
          if (!r_valid) begin
            r_dout     <= r_csum;
            r_dout_idx <= ADDR_W'(NUM_REGS);
            r_valid    <= 1'b1;
          end else if (i_dout_ready) begin
            r_valid <= 1'b0;
          end
`endif
        default: ;
      endcase
    end
  end

  assign o_a4         = r_a4;
  assign o_dout       = r_dout;
  assign o_dout_idx   = r_dout_idx;
  assign o_dout_valid = r_valid;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_FIN);

endmodule
